// File: rtl/riscv_icache_miss_ctrl_if.sv
// Fetch/tag/DRAM handshake bundle between the instruction-cache miss
// controller and its surroundings.
interface riscv_icache_miss_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             fetch_req;
  logic             misaligned;
  logic             hit;
  logic             hit_missalign;
  logic             mem_ready;
  logic             stall;
  logic             mem_req;
  logic             mem_sel;
  logic             data_we;
  logic             replace_tag;
  logic             valid_in;
  logic             replace_tag_align;
  logic             valid_in_align;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    input  fetch_req, misaligned, hit, hit_missalign, mem_ready,
    output stall, mem_req, mem_sel, data_we, replace_tag, valid_in,
           replace_tag_align, valid_in_align, miss_cnt
  );

  modport slave (
    output fetch_req, misaligned, hit, hit_missalign, mem_ready,
    input  stall, mem_req, mem_sel, data_we, replace_tag, valid_in,
           replace_tag_align, valid_in_align, miss_cnt
  );
endinterface

// File: rtl/riscv_icache_miss_ctrl.sv
// Instruction-cache miss controller: fills the addressed block and/or the
// following block (misaligned fetch) from DRAM, one block per mem_ready pulse.
module riscv_icache_miss_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  riscv_icache_miss_ctrl_if.master       bus
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] FILL_MAIN  = 2'd1;
  localparam logic [1:0] FILL_ALIGN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic fetch_done;
  logic stall, mem_req, mem_sel, data_we;
  logic replace_tag, valid_in, replace_tag_align, valid_in_align;

  always_comb begin
    state_d           = state_q;
    fetch_done        = bus.fetch_req & bus.hit & (~bus.misaligned | bus.hit_missalign);
    stall             = 1'b0;
    mem_req           = 1'b0;
    mem_sel           = 1'b0;
    data_we           = 1'b0;
    replace_tag       = 1'b0;
    valid_in          = 1'b0;
    replace_tag_align = 1'b0;
    valid_in_align    = 1'b0;

    case (state_q)
      IDLE: begin
        stall = bus.fetch_req & ~fetch_done;
        if (bus.fetch_req && !bus.hit) begin
          state_d = FILL_MAIN;
        end else if (bus.fetch_req && bus.misaligned && !bus.hit_missalign) begin
          state_d = FILL_ALIGN;
        end
      end
      FILL_MAIN: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          data_we     = 1'b1;
          replace_tag = 1'b1;
          valid_in    = 1'b1;
          state_d     = (bus.misaligned && !bus.hit_missalign) ? FILL_ALIGN : IDLE;
        end
      end
      FILL_ALIGN: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_sel = 1'b1;
        if (bus.mem_ready) begin
          data_we           = 1'b1;
          replace_tag_align = 1'b1;
          valid_in_align    = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter advances only on real fills; reset forces every strobe low.
    miss_cnt_d = miss_cnt_q + {{(CNT_W-1){1'b0}}, data_we};
    if (!rst) begin
      stall             = 1'b0;
      mem_req           = 1'b0;
      mem_sel           = 1'b0;
      data_we           = 1'b0;
      replace_tag       = 1'b0;
      valid_in          = 1'b0;
      replace_tag_align = 1'b0;
      valid_in_align    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.stall             = stall;
  assign bus.mem_req           = mem_req;
  assign bus.mem_sel           = mem_sel;
  assign bus.data_we           = data_we;
  assign bus.replace_tag       = replace_tag;
  assign bus.valid_in          = valid_in;
  assign bus.replace_tag_align = replace_tag_align;
  assign bus.valid_in_align    = valid_in_align;
  assign bus.miss_cnt          = miss_cnt_q;

endmodule

// File: tb/tb_riscv_icache_miss_ctrl.sv
// Directed scoreboard bench for riscv_icache_miss_ctrl (CNT_W=2 to exercise wrap).
module tb_riscv_icache_miss_ctrl;

  localparam int unsigned CNT_W = 2;

  typedef struct {
    string      name;
    logic [7:0] outs;
    logic [1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  riscv_icache_miss_ctrl_if #(.CNT_W(CNT_W)) bus ();

  riscv_icache_miss_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Output order: stall, mem_req, mem_sel, data_we, replace_tag, valid_in,
  // replace_tag_align, valid_in_align
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e   = exp_q.pop_front();
      got = {bus.stall, bus.mem_req, bus.mem_sel, bus.data_we, bus.replace_tag,
             bus.valid_in, bus.replace_tag_align, bus.valid_in_align};
      n_checks++;
      if (got !== e.outs) begin
        n_fails++;
        $display("FAIL %s outs: got %b expected %b", e.name, got, e.outs);
      end
      n_checks++;
      if (bus.miss_cnt !== e.cnt) begin
        n_fails++;
        $display("FAIL %s miss_cnt: got %0d expected %0d", e.name, bus.miss_cnt, e.cnt);
      end
      if (bus.replace_tag && bus.replace_tag_align) begin
        n_fails++;
        $display("FAIL %s strobe_overlap: got 1 expected 0", e.name);
      end
    end
  end

  task automatic vec(input string name, input logic r, input logic fr, input logic mis,
                     input logic h, input logic hm, input logic mr,
                     input logic [7:0] outs, input logic [1:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.fetch_req     = fr;
    bus.misaligned    = mis;
    bus.hit           = h;
    bus.hit_missalign = hm;
    bus.mem_ready     = mr;
    e.name = name;
    e.outs = outs;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    rst               = 1'b0;
    bus.fetch_req     = 1'b0;
    bus.misaligned    = 1'b0;
    bus.hit           = 1'b0;
    bus.hit_missalign = 1'b0;
    bus.mem_ready     = 1'b0;

    //   name           rst fr mis hit hm mr  outs         cnt
    vec("reset0",        0, 1, 0,  0,  0, 0, 8'b0000_0000, 2'd0);
    vec("reset_mr",      0, 1, 0,  0,  0, 1, 8'b0000_0000, 2'd0);
    vec("post_rst_mr",   1, 0, 0,  0,  0, 1, 8'b0000_0000, 2'd0);
    vec("hit",           1, 1, 0,  1,  0, 0, 8'b0000_0000, 2'd0);
    vec("hit_mis_both",  1, 1, 1,  1,  1, 0, 8'b0000_0000, 2'd0);
    // aligned miss, mem_ready five cycles after the miss
    vec("amiss_idle",    1, 1, 0,  0,  0, 0, 8'b1000_0000, 2'd0);
    for (int unsigned i = 0; i < 4; i++)
      vec("amiss_wait",  1, 1, 0,  0,  0, 0, 8'b1100_0000, 2'd0);
    vec("amiss_done",    1, 1, 0,  0,  0, 1, 8'b1101_1100, 2'd0);
    vec("amiss_rehit",   1, 1, 0,  1,  0, 0, 8'b0000_0000, 2'd1);
    // double miss
    vec("dmiss_idle",    1, 1, 1,  0,  0, 0, 8'b1000_0000, 2'd1);
    vec("dmiss_main",    1, 1, 1,  0,  0, 0, 8'b1100_0000, 2'd1);
    vec("dmiss_main_rd", 1, 1, 1,  0,  0, 1, 8'b1101_1100, 2'd1);
    vec("dmiss_align",   1, 1, 1,  1,  0, 0, 8'b1110_0000, 2'd2);
    vec("dmiss_al_rd",   1, 1, 1,  1,  0, 1, 8'b1111_0011, 2'd2);
    vec("dmiss_rehit",   1, 1, 1,  1,  1, 0, 8'b0000_0000, 2'd3);
    // next-block-only miss, fetch_req dropped mid-fill; fourth fill wraps the counter
    vec("nmiss_idle",    1, 1, 1,  1,  0, 0, 8'b1000_0000, 2'd3);
    vec("nmiss_align",   1, 0, 0,  0,  0, 0, 8'b1110_0000, 2'd3);
    vec("nmiss_al_rd",   1, 0, 0,  0,  0, 1, 8'b1111_0011, 2'd3);
    vec("wrap_idle",     1, 0, 0,  0,  0, 0, 8'b0000_0000, 2'd0);
    // spurious mem_ready in IDLE
    vec("spur_mr",       1, 0, 0,  0,  0, 1, 8'b0000_0000, 2'd0);
    vec("spur_after",    1, 0, 0,  0,  0, 0, 8'b0000_0000, 2'd0);
    // one quick fill, then reset in the middle of a second fill
    vec("q_idle",        1, 1, 0,  0,  0, 0, 8'b1000_0000, 2'd0);
    vec("q_done",        1, 1, 0,  0,  0, 1, 8'b1101_1100, 2'd0);
    vec("r_idle",        1, 1, 0,  0,  0, 0, 8'b1000_0000, 2'd1);
    vec("r_main",        1, 1, 0,  0,  0, 0, 8'b1100_0000, 2'd1);
    vec("r_assert",      0, 1, 0,  0,  0, 0, 8'b0000_0000, 2'd1);
    vec("r_release_mr",  1, 0, 0,  0,  0, 1, 8'b0000_0000, 2'd0);
    vec("r_hit",         1, 1, 0,  1,  0, 0, 8'b0000_0000, 2'd0);

    begin : drain
      int unsigned budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
        @(negedge clk);
        budget++;
      end
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fails++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
